// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep capture block.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  localparam logic [15:0] SIG_POLY   = 16'h1021;
  localparam logic [15:0] SIG_INIT   = 16'hFFFF;
  localparam int          N_IN_DEF   = 7;
  localparam int          SETTLE_DEF = 1;

  // One MSB-first serial CRC-16 step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [15:0] sig_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? SIG_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tt_sig_lfsr.sv
// Serial CRC-16 accumulator: one sampled bit per enable, clear reloads SIG_INIT.
module tt_sig_lfsr
  import tt_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // CRC register: clear has priority so a new sweep always starts from SIG_INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_crc <= SIG_INIT;
    else if (i_clr) r_crc <= SIG_INIT;
    else if (i_en)  r_crc <= sig_step(r_crc, i_bit);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/tt_sweep_capture.sv
// Truth-table sweep capture: walks every input vector of an N_IN-input netlist,
// samples its single output after SETTLE extra cycles and builds the table.
// Optional CRC-16 signature over the sampled bits with TT_SIGNATURE_EN.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  input  logic                 y_in,
  output logic [N_IN-1:0]      x_out,
  output logic                 busy,
  output logic                 done,
  output logic                 tt_valid,
  output logic [(1<<N_IN)-1:0] tt,
  output logic [N_IN:0]        ones_cnt
`ifdef TT_SIGNATURE_EN
  ,
  output logic [15:0]          sig
`endif
);

  localparam int TT_W = 1 << N_IN;

  state_e            r_state, w_state_nxt;
  logic [N_IN:0]     r_vec;      // one spare bit so the last index never wraps
  logic [3:0]        r_settle;
  logic [TT_W-1:0]   r_tt;
  logic [N_IN:0]     r_ones;
  logic              r_tt_valid;
  logic              w_accept, w_sample, w_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle controls: accept, sample, last-vector.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (!hold && r_settle == 4'(SETTLE)) begin
          w_sample = 1'b1;
          if (r_vec == (N_IN+1)'(TT_W-1)) begin
            w_last      = 1'b1;
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sweep datapath: vector/settle counters, table and ones count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec      <= '0;
      r_settle   <= '0;
      r_tt       <= '0;
      r_ones     <= '0;
      r_tt_valid <= 1'b0;
    end else if (w_accept) begin
      r_vec      <= '0;
      r_settle   <= '0;
      r_tt       <= '0;
      r_ones     <= '0;
      r_tt_valid <= 1'b0;
    end else if (r_state == ST_DRIVE && !hold) begin
      if (w_sample) begin
        r_tt[r_vec[N_IN-1:0]] <= y_in;
        r_ones                <= r_ones + (N_IN+1)'(y_in);
        if (!w_last) begin
          r_vec    <= r_vec + 1'b1;
          r_settle <= '0;
        end
      end else begin
        r_settle <= r_settle + 1'b1;
      end
    end else if (r_state == ST_FIN) begin
      r_tt_valid <= 1'b1;
    end
  end

  assign x_out    = r_vec[N_IN-1:0];
  assign busy     = (r_state == ST_DRIVE);
  assign done     = (r_state == ST_FIN);
  assign tt_valid = r_tt_valid;
  assign tt       = r_tt;
  assign ones_cnt = r_ones;

`ifdef TT_SIGNATURE_EN
  tt_sig_lfsr u_sig (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (w_sample),
    .i_bit (y_in),
    .o_crc (sig)
  );
`endif

endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Sequential truth-table extractor that drives every input vector of an N_IN-input combinational benchmark function (the optimised single-output restriction netlists, e.g. 7 inputs x0..x6 -> y0) and captures the response into a 2^N_IN-bit truth table. Sits directly upstream and downstream of the netlist under test: `x_out` feeds the netlist inputs, and `y_in` takes its single output. The captured table, its ones count and an optional signature feed the autosymmetry and restriction analysis flow.

## Interface
- `N_IN`, 7: number of netlist inputs; legal range 1..10.
- `SETTLE`, 1: extra hold cycles per vector before sampling; legal range 0..15.
- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `hold`  in  1  pauses the sweep (freezes vector and settle counter).
- `y_in`  in  1  netlist output for the current `x_out`.
- `x_out`  out  N_IN  current input vector; bit i drives netlist input xi.
- `busy`  out  1  high from accept until the last sample.
- `done`  out  1  one-cycle pulse after the last sample.
- `tt_valid`  out  1  table complete; held until next accepted start or reset.
- `tt`  out  2^N_IN  captured table; bit k = y_in for x_out==k.
- `ones_cnt`  out  N_IN+1  number of 1s in `tt`.
- `sig`  out  16  CRC signature; present only with TT_SIGNATURE_EN.

## Operation
- States: IDLE, DRIVE, FIN.
- IDLE: `start`=1 -> DRIVE with vec=0, settle=0, tt=0, ones_cnt=0, tt_valid=0, sig=SIG_INIT.
- DRIVE, `hold`=1: no state change, no sample.
- DRIVE, `hold`=0, settle<SETTLE: settle+1.
- DRIVE, `hold`=0, settle==SETTLE: write tt[vec]=y_in and add y_in to ones_cnt. Then:
  - if vec==2^N_IN-1: go to FIN;
  - else vec+1 and settle=0.
- FIN: lasts one cycle. Pulses `done`, sets tt_valid=1, then returns to IDLE.
- `start` outside IDLE is ignored. `start` and `hold` together in IDLE: the start is accepted, and hold applies from the next cycle.
- vec is N_IN+1 bits internally, so no wrap occurs. `x_out`=vec[N_IN-1:0].
- `busy`=1 in DRIVE only.
- Reset is legal at any time, including mid-sweep. It forces IDLE, x_out=0, busy=0, done=0, tt_valid=0, tt=0, ones_cnt=0, sig=SIG_INIT.

## Timing
- Start accepted at edge e0 -> x_out=0 and busy=1 visible after e0.
- Each vector occupies SETTLE+1 non-hold cycles. y_in is sampled at the edge that ends the window.
- `done` is high in the cycle after edge e0 + 2^N_IN*(SETTLE+1) + H, where H is the number of hold cycles. `busy` falls at that same edge.
- Earliest new start: the cycle after `done`.
- `x_out` is registered, so no combinational path exists from `y_in` or `start` to any output.

## Configuration
- `TT_SIGNATURE_EN` defined:
  - adds port `sig`;
  - runs a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final xor), shifting in each sampled bit in vector order;
  - `sig` is final when tt_valid=1.
- Not defined: port `sig` and its LFSR are absent. All other behaviour is identical.

## Structure
- Package `tt_sweep_pkg` holds:
  - the state enum (IDLE, DRIVE, FIN);
  - SIG_POLY=16'h1021 and SIG_INIT=16'hFFFF;
  - the default N_IN and SETTLE constants.
- Sub-module `tt_sig_lfsr` (1-bit serial CRC with enable, clear and async reset) is instantiated only under TT_SIGNATURE_EN.

## Test plan
- N_IN=7, SETTLE=1, y_in tied 0 -> tt=0, ones_cnt=0, done pulse exactly 256 cycles after start accept, tt_valid=1.
- N_IN=7, SETTLE=0, y_in=x_out[0] -> tt={64{2'b10}}, ones_cnt=64, done 128 cycles after accept.
- y_in=x_out[0]&x_out[1] -> tt={32{4'b1000}}, ones_cnt=32. The `sig` value matches the software CRC model over the same 128 bits.
- hold=1 for 10 cycles at vector 40 -> x_out stays 40, done delayed by exactly 10 cycles, tt identical to the no-hold run.
- start pulsed again at vector 20 -> ignored: no restart, tt and timing unchanged.
- rst_n low at vector 50 -> all outputs at reset values. A new start yields the complete correct table.
